// File: rtl/axi4_mem_slave_model_if.sv
// AXI4 memory channel bundle between FPGATop (master) and the memory
// responder model (slave). Signal names follow the mem_N channel with the
// "mem_" prefix carried by the interface instance name.
interface axi4_mem_slave_model_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 4
);
    localparam int BYTES = DATA_BITS / 8;

    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_BITS-1:0] ar_bits_addr;
    logic [ID_BITS-1:0]   ar_bits_id;
    logic [2:0]           ar_bits_size;
    logic [7:0]           ar_bits_len;

    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_BITS-1:0] aw_bits_addr;
    logic [ID_BITS-1:0]   aw_bits_id;
    logic [2:0]           aw_bits_size;
    logic [7:0]           aw_bits_len;

    logic                 w_valid;
    logic                 w_ready;
    logic [BYTES-1:0]     w_bits_strb;
    logic [DATA_BITS-1:0] w_bits_data;
    logic                 w_bits_last;

    logic                 r_valid;
    logic                 r_ready;
    logic [1:0]           r_bits_resp;
    logic [ID_BITS-1:0]   r_bits_id;
    logic [DATA_BITS-1:0] r_bits_data;
    logic                 r_bits_last;

    logic                 b_valid;
    logic                 b_ready;
    logic [1:0]           b_bits_resp;
    logic [ID_BITS-1:0]   b_bits_id;

    modport master (
        output ar_valid, ar_bits_addr, ar_bits_id, ar_bits_size, ar_bits_len,
        input  ar_ready,
        output aw_valid, aw_bits_addr, aw_bits_id, aw_bits_size, aw_bits_len,
        input  aw_ready,
        output w_valid, w_bits_strb, w_bits_data, w_bits_last,
        input  w_ready,
        input  r_valid, r_bits_resp, r_bits_id, r_bits_data, r_bits_last,
        output r_ready,
        input  b_valid, b_bits_resp, b_bits_id,
        output b_ready
    );

    modport slave (
        input  ar_valid, ar_bits_addr, ar_bits_id, ar_bits_size, ar_bits_len,
        output ar_ready,
        input  aw_valid, aw_bits_addr, aw_bits_id, aw_bits_size, aw_bits_len,
        output aw_ready,
        input  w_valid, w_bits_strb, w_bits_data, w_bits_last,
        output w_ready,
        output r_valid, r_bits_resp, r_bits_id, r_bits_data, r_bits_last,
        input  r_ready,
        output b_valid, b_bits_resp, b_bits_id,
        input  b_ready
    );
endinterface

// File: rtl/axi4_mem_slave_model.sv
// AXI4 memory responder for one FPGATop mem_N channel. Word-addressed
// backing store, one read burst and one write burst in flight concurrently,
// INCR bursts only, index wraps at the top of the store.
// Optional feature: define AXI4_MEM_SLAVE_DECERR_EN to answer beats that run
// past the top of the store with DECERR (data 0, writes suppressed) instead
// of wrapping silently.
module axi4_mem_slave_model #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int ID_BITS      = 4,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input logic clock,
    input logic reset,
    axi4_mem_slave_model_if.slave mem
);
    localparam int              BYTES     = DATA_BITS / 8;
    localparam int              OFF       = $clog2(BYTES);
    localparam int              WORDS     = 2 ** DEPTH_LOG2;
    localparam logic [2:0]      SIZE_OK   = 3'(OFF);
    localparam logic [7:0]      WAIT_INIT = (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [1:0]      RESP_DECERR = 2'b11;
`ifdef AXI4_MEM_SLAVE_DECERR_EN
    localparam bit              DECERR_EN = 1'b1;
`else
    localparam bit              DECERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    logic [DATA_BITS-1:0] store [0:WORDS-1];

    rd_state_t             rd_state;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_over;      // index has run past the top of the store
    logic [7:0]            rd_len;
    logic [7:0]            rd_beat;
    logic [7:0]            rd_wait;
    logic                  rd_size_err;

    wr_state_t             wr_state;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  wr_over;
    logic [7:0]            wr_len;
    logic [7:0]            wr_beat;
    logic                  wr_size_err;
    logic                  wr_dec;       // a DECERR beat was seen earlier in this burst

    logic rd_dec_now;
    logic w_fire;
    logic wr_dec_now;
    logic wr_beat_last;
    logic wr_en;

    assign rd_dec_now   = DECERR_EN && rd_over;
    assign w_fire       = mem.w_valid && mem.w_ready;
    assign wr_dec_now   = DECERR_EN && wr_over;
    assign wr_beat_last = (wr_beat == wr_len);
    assign wr_en        = w_fire && !wr_size_err && !wr_dec_now;

    // Byte-enabled store write for each accepted W beat.
    // NOTE: the backing store has no reset; its contents survive reset and start undefined.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem.w_bits_strb[b]) begin
                    store[wr_idx][8*b +: 8] <= mem.w_bits_data[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: accept AR, wait READ_LATENCY cycles, then stream registered beats.
    // NOTE: all sequential state uses non-blocking assignments, so a same-cycle
    // store write is not visible to the beat loaded on that edge (old data returned).
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state         <= RD_IDLE;
            rd_idx           <= '0;
            rd_over          <= 1'b0;
            rd_len           <= '0;
            rd_beat          <= '0;
            rd_wait          <= '0;
            rd_size_err      <= 1'b0;
            mem.ar_ready     <= 1'b0;
            mem.r_valid      <= 1'b0;
            mem.r_bits_resp  <= '0;
            mem.r_bits_id    <= '0;
            mem.r_bits_data  <= '0;
            mem.r_bits_last  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    mem.ar_ready <= 1'b1;
                    if (mem.ar_valid && mem.ar_ready) begin
                        mem.ar_ready  <= 1'b0;
                        mem.r_bits_id <= mem.ar_bits_id;
                        rd_idx        <= mem.ar_bits_addr[OFF +: DEPTH_LOG2];
                        rd_over       <= 1'b0;
                        rd_len        <= mem.ar_bits_len;
                        rd_beat       <= '0;
                        rd_size_err   <= (mem.ar_bits_size != SIZE_OK);
                        rd_wait       <= WAIT_INIT;
                        rd_state      <= (READ_LATENCY == 0) ? RD_DATA : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_wait == 8'd0) begin
                        rd_state <= RD_DATA;
                    end else begin
                        rd_wait <= rd_wait - 8'd1;
                    end
                end
                RD_DATA: begin
                    if (!mem.r_valid || mem.r_ready) begin
                        if (mem.r_valid && mem.r_bits_last) begin
                            mem.r_valid     <= 1'b0;
                            mem.r_bits_last <= 1'b0;
                            mem.ar_ready    <= 1'b1;
                            rd_state        <= RD_IDLE;
                        end else begin
                            mem.r_valid     <= 1'b1;
                            mem.r_bits_data <= rd_dec_now ? '0 : store[rd_idx];
                            mem.r_bits_resp <= rd_dec_now ? RESP_DECERR :
                                               rd_size_err ? RESP_SLVERR : RESP_OKAY;
                            mem.r_bits_last <= (rd_beat == rd_len);
                            rd_beat         <= rd_beat + 8'd1;
                            rd_idx          <= rd_idx + 1'b1;
                            if (&rd_idx) rd_over <= 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: accept AW, take W beats until w_last or beat len, then hold B.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state        <= WR_IDLE;
            wr_idx          <= '0;
            wr_over         <= 1'b0;
            wr_len          <= '0;
            wr_beat         <= '0;
            wr_size_err     <= 1'b0;
            wr_dec          <= 1'b0;
            mem.aw_ready    <= 1'b0;
            mem.w_ready     <= 1'b0;
            mem.b_valid     <= 1'b0;
            mem.b_bits_resp <= '0;
            mem.b_bits_id   <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    mem.aw_ready <= 1'b1;
                    if (mem.aw_valid && mem.aw_ready) begin
                        mem.aw_ready  <= 1'b0;
                        mem.w_ready   <= 1'b1;
                        mem.b_bits_id <= mem.aw_bits_id;
                        wr_idx        <= mem.aw_bits_addr[OFF +: DEPTH_LOG2];
                        wr_over       <= 1'b0;
                        wr_len        <= mem.aw_bits_len;
                        wr_beat       <= '0;
                        wr_size_err   <= (mem.aw_bits_size != SIZE_OK);
                        wr_dec        <= 1'b0;
                        wr_state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        wr_beat <= wr_beat + 8'd1;
                        wr_idx  <= wr_idx + 1'b1;
                        if (&wr_idx) wr_over <= 1'b1;
                        wr_dec  <= wr_dec || wr_dec_now;
                        if (mem.w_bits_last || wr_beat_last) begin
                            mem.w_ready     <= 1'b0;
                            mem.b_valid     <= 1'b1;
                            mem.b_bits_resp <= (wr_dec || wr_dec_now) ? RESP_DECERR :
                                               (wr_size_err || (mem.w_bits_last != wr_beat_last)) ?
                                               RESP_SLVERR : RESP_OKAY;
                            wr_state        <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (mem.b_ready) begin
                        mem.b_valid  <= 1'b0;
                        mem.aw_ready <= 1'b1;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end
endmodule
